// File: rtl/audio_seq_pkg.sv
// Shared types and constants for the audio frame sequencer.
package audio_seq_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PROC    = 2'd1,
        EMIT    = 2'd2
    } state_t;

    typedef logic signed [DEFAULT_DATA_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

endpackage : audio_seq_pkg

// File: rtl/audio_frame_sequencer_stereo_out_hold.sv
// Dual-channel output hold register. Each channel presents its sample until
// its own ready retires it; both_done_o pulses combinationally in the cycle
// the last outstanding channel retires.
module stereo_out_hold #(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_l_i,
    input  logic [DATA_W-1:0] load_r_i,
    output logic [DATA_W-1:0] l_data_o,
    output logic              l_valid_o,
    input  logic              l_ready_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic              r_valid_o,
    input  logic              r_ready_i,
    output logic              both_done_o
);

    logic [DATA_W-1:0] l_data_q, l_data_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              l_valid_q, l_valid_d;
    logic              r_valid_q, r_valid_d;

    // Next-state: load both channels together, retire each on its own handshake.
    always_comb begin
        l_data_d  = l_data_q;
        r_data_d  = r_data_q;
        l_valid_d = l_valid_q & ~l_ready_i;
        r_valid_d = r_valid_q & ~r_ready_i;
        if (load_i) begin
            l_data_d  = load_l_i;
            r_data_d  = load_r_i;
            l_valid_d = 1'b1;
            r_valid_d = 1'b1;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            l_data_q  <= '0;
            r_data_q  <= '0;
            l_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            l_data_q  <= l_data_d;
            r_data_q  <= r_data_d;
            l_valid_q <= l_valid_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign l_data_o    = l_data_q;
    assign r_data_o    = r_data_q;
    assign l_valid_o   = l_valid_q;
    assign r_valid_o   = r_valid_q;
    assign both_done_o = (l_valid_q | r_valid_q) & ~l_valid_d & ~r_valid_d & ~load_i;

endmodule : stereo_out_hold

// File: rtl/audio_frame_sequencer.sv
// Audio frame sequencer: pairs left/right ADC samples into a frame, optionally
// routes it through an external processing core with a timeout fallback to the
// dry frame, and presents the result to both DAC sinks.
// Optional feature macro: MONO_MIX_EN (mix the captured frame down to mono).
module audio_frame_sequencer
    import audio_seq_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int PROC_TIMEOUT = 1024,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] left_in_data,
    input  logic              left_in_valid,
    output logic              left_in_ready,
    input  logic [DATA_W-1:0] right_in_data,
    input  logic              right_in_valid,
    output logic              right_in_ready,
    output logic              proc_req,
    output logic [DATA_W-1:0] proc_left,
    output logic [DATA_W-1:0] proc_right,
    input  logic              proc_ack,
    input  logic [DATA_W-1:0] proc_left_res,
    input  logic [DATA_W-1:0] proc_right_res,
    output logic [DATA_W-1:0] left_out_data,
    output logic              left_out_valid,
    input  logic              left_out_ready,
    output logic [DATA_W-1:0] right_out_data,
    output logic              right_out_valid,
    input  logic              right_out_ready,
    input  logic              bypass,
    input  logic              clear_status,
    output logic              timeout_flag,
    output logic [CNT_W-1:0]  timeout_count
);

    localparam int TMR_W = (PROC_TIMEOUT > 1) ? $clog2(PROC_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PROC_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              have_l_q, have_l_d;
    logic              have_r_q, have_r_d;
    logic [DATA_W-1:0] cap_l_q, cap_l_d;
    logic [DATA_W-1:0] cap_r_q, cap_r_d;
    logic              lrdy_q, lrdy_d;
    logic              rrdy_q, rrdy_d;
    logic              preq_q, preq_d;
    logic [DATA_W-1:0] pl_q, pl_d;
    logic [DATA_W-1:0] pr_q, pr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              flag_q, flag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              load;
    logic [DATA_W-1:0] load_l, load_r;
    logic [DATA_W-1:0] dry_l, dry_r;
    logic              both_done;

    // Dry-frame formation from the frame as it stands after this cycle's captures.
    always_comb begin
`ifdef MONO_MIX_EN
        logic [DATA_W:0] sum;
        sum   = {cap_l_d[DATA_W-1], cap_l_d} + {cap_r_d[DATA_W-1], cap_r_d};
        dry_l = sum[DATA_W:1];
        dry_r = sum[DATA_W:1];
`else
        dry_l = cap_l_d;
        dry_r = cap_r_d;
`endif
    end

    // Sequencer next-state, handshake and status logic.
    always_comb begin
        state_d  = state_q;
        have_l_d = have_l_q;
        have_r_d = have_r_q;
        cap_l_d  = cap_l_q;
        cap_r_d  = cap_r_q;
        preq_d   = preq_q;
        pl_d     = pl_q;
        pr_d     = pr_q;
        timer_d  = timer_q;
        flag_d   = flag_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        load_l   = '0;
        load_r   = '0;

        case (state_q)
            COLLECT: begin
                if (left_in_valid && lrdy_q) begin
                    cap_l_d  = left_in_data;
                    have_l_d = 1'b1;
                end
                if (right_in_valid && rrdy_q) begin
                    cap_r_d  = right_in_data;
                    have_r_d = 1'b1;
                end
                if (have_l_d && have_r_d) begin
                    if (bypass) begin
                        load    = 1'b1;
                        load_l  = dry_l;
                        load_r  = dry_r;
                        state_d = EMIT;
                    end else begin
                        preq_d  = 1'b1;
                        pl_d    = dry_l;
                        pr_d    = dry_r;
                        timer_d = '0;
                        state_d = PROC;
                    end
                end
            end
            PROC: begin
                if (proc_ack) begin
                    load    = 1'b1;
                    load_l  = proc_left_res;
                    load_r  = proc_right_res;
                    preq_d  = 1'b0;
                    state_d = EMIT;
                end else if (timer_q == TMR_LAST) begin
                    // The held operands are the dry frame, so they double as the fallback output.
                    load    = 1'b1;
                    load_l  = pl_q;
                    load_r  = pr_q;
                    preq_d  = 1'b0;
                    flag_d  = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = EMIT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            EMIT: begin
                if (both_done) begin
                    have_l_d = 1'b0;
                    have_r_d = 1'b0;
                    state_d  = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        if (clear_status) begin
            flag_d = 1'b0;
            cnt_d  = '0;
        end

        lrdy_d = (state_d == COLLECT) && !have_l_d;
        rrdy_d = (state_d == COLLECT) && !have_r_d;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= COLLECT;
            have_l_q <= 1'b0;
            have_r_q <= 1'b0;
            cap_l_q  <= '0;
            cap_r_q  <= '0;
            lrdy_q   <= 1'b0;
            rrdy_q   <= 1'b0;
            preq_q   <= 1'b0;
            pl_q     <= '0;
            pr_q     <= '0;
            timer_q  <= '0;
            flag_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            have_l_q <= have_l_d;
            have_r_q <= have_r_d;
            cap_l_q  <= cap_l_d;
            cap_r_q  <= cap_r_d;
            lrdy_q   <= lrdy_d;
            rrdy_q   <= rrdy_d;
            preq_q   <= preq_d;
            pl_q     <= pl_d;
            pr_q     <= pr_d;
            timer_q  <= timer_d;
            flag_q   <= flag_d;
            cnt_q    <= cnt_d;
        end
    end

    stereo_out_hold #(
        .DATA_W (DATA_W)
    ) u_out_hold (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (load),
        .load_l_i    (load_l),
        .load_r_i    (load_r),
        .l_data_o    (left_out_data),
        .l_valid_o   (left_out_valid),
        .l_ready_i   (left_out_ready),
        .r_data_o    (right_out_data),
        .r_valid_o   (right_out_valid),
        .r_ready_i   (right_out_ready),
        .both_done_o (both_done)
    );

    assign left_in_ready  = lrdy_q;
    assign right_in_ready = rrdy_q;
    assign proc_req       = preq_q;
    assign proc_left      = pl_q;
    assign proc_right     = pr_q;
    assign timeout_flag   = flag_q;
    assign timeout_count  = cnt_q;

endmodule : audio_frame_sequencer

// File: doc/audio_frame_sequencer.md
Name: audio_frame_sequencer

Overview:
Sits between the codec's left/right ADC Avalon-ST sources and its left/right DAC Avalon-ST sinks.
- Pairs one left and one right sample into a stereo frame.
- Hands the frame to an external pitch-processing core over a req/ack handshake, or bypasses the core.
- Presents the result to both DAC sinks with proper valid/ready holding.
- A processing timeout guarantees output cadence if the core stalls; the dry frame is emitted instead.

Parameters:
DATA_W, 16, sample width (two's complement)
PROC_TIMEOUT, 1024, max cycles proc_req may stay high without proc_ack before the dry frame is emitted
CNT_W, 8, width of saturating timeout counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
left_in_data  in  DATA_W  ADC left sample
left_in_valid  in  1  ADC left valid
left_in_ready  out  1  accept left sample
right_in_data  in  DATA_W  ADC right sample
right_in_valid  in  1  ADC right valid
right_in_ready  out  1  accept right sample
proc_req  out  1  frame offered to processing core
proc_left  out  DATA_W  left operand, stable while proc_req
proc_right  out  DATA_W  right operand, stable while proc_req
proc_ack  in  1  core result valid, single cycle
proc_left_res  in  DATA_W  processed left, sampled with proc_ack
proc_right_res  in  DATA_W  processed right, sampled with proc_ack
left_out_data  out  DATA_W  DAC left sample
left_out_valid  out  1  DAC left valid
left_out_ready  in  1  DAC left ready
right_out_data  out  DATA_W  DAC right sample
right_out_valid  out  1  DAC right valid
right_out_ready  in  1  DAC right ready
bypass  in  1  skip processing core
clear_status  in  1  clear timeout_flag/timeout_count
timeout_flag  out  1  sticky: at least one timeout occurred
timeout_count  out  CNT_W  saturating count of timed-out frames

Behaviour:
- Reset: state COLLECT. All outputs are 0: readies, valids, proc_req, data, flag and count. The have_l/have_r flags are cleared and the timer is 0. Reset mid-operation abandons the frame; no partial output appears.
- Avalon-ST handshakes:
  - A transfer occurs on any cycle with valid&ready high.
  - Ready is level-based, not one-shot.
  - Output valid and data are held stable until the matching ready is seen.
- COLLECT:
  - left_in_ready = !have_l and right_in_ready = !have_r (registered, updated each cycle).
  - A transfer captures the sample and sets the corresponding have flag. Both channels may transfer in the same cycle.
  - When both flags are set, leave COLLECT next cycle and drop both readies. bypass is sampled on this transition only.
- bypass=1: go to EMIT with the dry frame. Outputs are valid 1 cycle after the second capture.
- bypass=0: go to PROC.
  - proc_req=1 with the operands held; the timer counts from 0.
  - proc_ack: latch the results, drop proc_req, and go to EMIT next cycle.
  - Timer reaches PROC_TIMEOUT-1 without ack: drop proc_req, emit the dry frame, set timeout_flag, and increment timeout_count (saturating at all-ones).
  - If ack and timeout occur in the same cycle, ack wins (no count).
  - proc_ack outside PROC is ignored.
- EMIT:
  - left_out_valid and right_out_valid rise together.
  - Each channel retires independently on its own valid&ready.
  - When both have retired (same or different cycles), clear the have flags and return to COLLECT.
  - Input readies re-assert the cycle after the last retire.
- clear_status has priority over a same-cycle increment.
- Arithmetic: no width growth except under MONO_MIX_EN.

Optional Feature:
MONO_MIX_EN
- Defined: the captured frame becomes mono: m = (L + R) >>> 1, computed in DATA_W+1 bits with sign extension and truncated back to DATA_W. m is used for both operands and for both dry outputs.
- Undefined: channels are passed independently, unmodified.

Decomposition:
- Package audio_seq_pkg:
  - state enum {COLLECT, PROC, EMIT}
  - localparam DEFAULT_DATA_W=16
  - typedef sample_t (logic signed [DATA_W-1:0])
  - typedef struct stereo_t {sample_t l, r}
- Sub-module stereo_out_hold: holds the dual-channel output register with independent per-channel valid/retire and a both_done pulse; instantiated once in EMIT.

Test Plan:
- bypass=1: L=0x1234 at cycle 5, R=0xFEDC at cycle 8 -> both out_valid at cycle 9 with the same data. The readies were 1 then 0, and return to 1 the cycle after retire.
- bypass=0: core acks 3 cycles after proc_req with res 0x0100/0x0200 -> outputs 0x0100/0x0200. proc_left/proc_right are stable 0x1234/0xFEDC throughout proc_req.
- bypass=0, PROC_TIMEOUT=8, no ack -> proc_req high exactly 8 cycles, dry frame emitted, timeout_flag=1, count=1. Ack and timeout in the same cycle -> processed data, count unchanged.
- left_out_ready=1 but right_out_ready held 0 for 20 cycles -> left retires immediately, right_out_valid/data held stable for 20 cycles, no new input accepted until it retires.
- reset asserted in PROC -> next cycle all outputs 0, state COLLECT. With MONO_MIX_EN: L=0x7FFF, R=0x7FFF -> 0x7FFF on both; L=0x8000, R=0xFFFF -> 0xBFFF.
